pipe_stage_reg: RTL

Parametrised, handshaked pipeline stage register that replaces the fixed, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the five-stage CPU. It carries one data payload and one control bundle per instruction, adds a valid bit, and supports back-pressure through a 2-entry skid buffer. It also supports flush (bubble insertion) for branch/jump redirect. Control outputs are masked when the stage holds a bubble, so write enables can never fire from invalid slots.

---
 rtl/pipe_stage_reg.sv | 84 ++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a 2-entry skid buffer, flush and
// bubble-masked control outputs.
module pipe_stage_reg #(
    parameter int                 DATA_W     = 96,
    parameter int                 CTRL_W     = 4,
    parameter logic [DATA_W-1:0]  RESET_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic in_fire;
    logic main_free;

    // in_ready comes straight from a flop, so it never sees out_ready
    // combinationally and upstream timing stays short.
    assign in_ready  = ~skid_valid;
    assign in_fire   = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset too because out_data has a
            // defined post-reset value; only the valid bits matter for flow.
            main_valid <= 1'b0;
            main_data  <= RESET_DATA;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            // Data is left alone; masking hides the stale control bundle.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // NOTE: non-blocking assignments let main read the old skid value
            // in the same edge that skid is reloaded.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                if (in_fire) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                    skid_ctrl  <= in_ctrl;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (in_fire) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            // Main is stalled; the one extra instruction in flight parks here.
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
        end
    end

endmodule
